// File: rtl/pulse_peak_pkg.sv
// rtl/pulse_peak_pkg.sv - shared types and field offsets for the pulse peak detector
package pulse_peak_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    EMIT0 = 2'd1,
    EMIT1 = 2'd2
  } state_e;

  // Result word 0 layout
  localparam int DETECT_BIT = 31;
  localparam int OVF_BIT    = 30;
  localparam int CNT_LSB    = 16;
  localparam int IDX_LSB    = 0;
  localparam int IDX_FIELD  = 16;

  // Averaged sample layout: {I, Q}, both signed
  localparam int IQ_W  = 16;
  localparam int I_LSB = 16;
  localparam int Q_LSB = 0;

endpackage

// File: rtl/cmag_sq_pipe.sv
// rtl/cmag_sq_pipe.sv - two-stage I^2+Q^2 power pipeline with index/last sideband
module cmag_sq_pipe
  import pulse_peak_pkg::*;
#(
  parameter int IDX_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [31:0]      data_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             last_i,
  output logic             valid_o,
  output logic [31:0]      pow_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic signed [31:0] i_ext;
  logic signed [31:0] q_ext;
  logic [31:0]        s1_ii_q, s1_qq_q;
  logic [IDX_W-1:0]   s1_idx_q;
  logic               s1_last_q, s1_valid_q;
  logic [31:0]        s2_pow_q;
  logic [IDX_W-1:0]   s2_idx_q;
  logic               s2_last_q, s2_valid_q;

  // Sign-extend so each square is formed at full 32-bit precision
  assign i_ext = {{(32-IQ_W){data_i[I_LSB+IQ_W-1]}}, data_i[I_LSB +: IQ_W]};
  assign q_ext = {{(32-IQ_W){data_i[Q_LSB+IQ_W-1]}}, data_i[Q_LSB +: IQ_W]};

  // Stage 1 squares, stage 2 sum; a square is at most 2^30 so the sum fits in 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ii_q    <= '0;
      s1_qq_q    <= '0;
      s1_idx_q   <= '0;
      s1_last_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_pow_q   <= '0;
      s2_idx_q   <= '0;
      s2_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_ii_q    <= $unsigned(i_ext * i_ext);
      s1_qq_q    <= $unsigned(q_ext * q_ext);
      s1_idx_q   <= idx_i;
      s1_last_q  <= last_i;
      s1_valid_q <= valid_i && !flush_i;
      s2_pow_q   <= s1_ii_q + s1_qq_q;
      s2_idx_q   <= s1_idx_q;
      s2_last_q  <= s1_last_q;
      s2_valid_q <= s1_valid_q && !flush_i;
    end
  end

  assign valid_o = s2_valid_q;
  assign pow_o   = s2_pow_q;
  assign idx_o   = s2_idx_q;
  assign last_o  = s2_last_q;

endmodule

// File: rtl/pulse_peak_detect.sv
// rtl/pulse_peak_detect.sv - per-pulse peak power search emitting a 2-beat result packet
module pulse_peak_detect
  import pulse_peak_pkg::*;
#(
  parameter int MAX_PULSE_SIZE = 8192,
  parameter int CNT_WIDTH      = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [31:0]  threshold,
  input  logic [31:0]  i_tdata,
  input  logic [127:0] i_tuser,
  input  logic         i_tvalid,
  input  logic         i_tlast,
  output logic         i_tready,
  output logic [31:0]  o_tdata,
  output logic [127:0] o_tuser,
  output logic         o_tvalid,
  output logic         o_tlast,
  input  logic         o_tready
);

  localparam int IDX_W = $clog2(MAX_PULSE_SIZE);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_PULSE_SIZE - 1);

  state_e               state_q;
  logic                 rdy_q, hold_q;
  logic [IDX_W-1:0]     bin_idx_q;
  logic                 idx_full_q, ovf_q;
  logic [CNT_WIDTH-1:0] pulse_cnt_q;
  logic [31:0]          peak_mag_q;
  logic [IDX_W-1:0]     peak_idx_q;
  logic [127:0]         hdr_q;
  logic [31:0]          o_data_q;
  logic                 o_tvalid_q, o_tlast_q;

  logic                 in_fire;
  logic                 s2_valid, s2_last;
  logic [31:0]          s2_pow;
  logic [IDX_W-1:0]     s2_idx;
  logic                 take;
  logic [31:0]          word0_d;

  assign in_fire = i_tvalid && rdy_q;

  cmag_sq_pipe #(.IDX_W(IDX_W)) u_pipe (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (clear),
    .valid_i (in_fire),
    .data_i  (i_tdata),
    .idx_i   (bin_idx_q),
    .last_i  (i_tlast),
    .valid_o (s2_valid),
    .pow_o   (s2_pow),
    .idx_o   (s2_idx),
    .last_o  (s2_last)
  );

  // First bin of a pulse always loads; later bins must be strictly larger so ties keep the earliest
  assign take = s2_valid && ((s2_idx == '0) || (s2_pow > peak_mag_q));

  // Word 0 without the detect bit, built from the peak as it stands after the final compare
  always_comb begin
    word0_d = '0;
    word0_d[OVF_BIT] = ovf_q;
    word0_d[CNT_LSB +: CNT_WIDTH] = pulse_cnt_q;
    word0_d[IDX_LSB +: IDX_W] = take ? s2_idx : peak_idx_q;
  end

  // Control FSM: accumulate a pulse, then emit index/flags and peak power
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ACCUM;
      rdy_q       <= 1'b0;
      hold_q      <= 1'b0;
      bin_idx_q   <= '0;
      idx_full_q  <= 1'b0;
      ovf_q       <= 1'b0;
      pulse_cnt_q <= '0;
      peak_mag_q  <= '0;
      peak_idx_q  <= '0;
      hdr_q       <= '0;
      o_data_q    <= '0;
      o_tvalid_q  <= 1'b0;
      o_tlast_q   <= 1'b0;
    end else if (clear) begin
      state_q     <= ACCUM;
      rdy_q       <= 1'b1;
      hold_q      <= 1'b0;
      bin_idx_q   <= '0;
      idx_full_q  <= 1'b0;
      ovf_q       <= 1'b0;
      pulse_cnt_q <= '0;
      peak_mag_q  <= '0;
      peak_idx_q  <= '0;
      o_data_q    <= '0;
      o_tvalid_q  <= 1'b0;
      o_tlast_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          // Input closes from the tlast beat until the result packet is out
          rdy_q <= !hold_q && !(in_fire && i_tlast);
          if (in_fire) begin
            if (bin_idx_q == '0) hdr_q <= i_tuser;
            if (idx_full_q) ovf_q <= 1'b1;
            if (bin_idx_q == IDX_MAX) idx_full_q <= 1'b1;
            else bin_idx_q <= bin_idx_q + IDX_W'(1);
            if (i_tlast) hold_q <= 1'b1;
          end
          if (take) begin
            peak_mag_q <= s2_pow;
            peak_idx_q <= s2_idx;
          end
          if (s2_valid && s2_last) begin
            state_q    <= EMIT0;
            hold_q     <= 1'b0;
            o_data_q   <= word0_d;
            o_tvalid_q <= 1'b1;
            o_tlast_q  <= 1'b0;
          end
        end
        EMIT0: begin
          if (o_tready) begin
            state_q   <= EMIT1;
            o_data_q  <= peak_mag_q;
            o_tlast_q <= 1'b1;
          end
        end
        EMIT1: begin
          if (o_tready) begin
            state_q     <= ACCUM;
            rdy_q       <= 1'b1;
            pulse_cnt_q <= pulse_cnt_q + CNT_WIDTH'(1);
            bin_idx_q   <= '0;
            idx_full_q  <= 1'b0;
            ovf_q       <= 1'b0;
            peak_mag_q  <= '0;
            peak_idx_q  <= '0;
            o_data_q    <= '0;
            o_tvalid_q  <= 1'b0;
            o_tlast_q   <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  // Detect follows the live threshold while word 0 is presented
  always_comb begin
    o_tdata = o_data_q;
    if (state_q == EMIT0) o_tdata[DETECT_BIT] = (peak_mag_q >= threshold);
  end

  assign i_tready = rdy_q;
  assign o_tuser  = hdr_q;
  assign o_tvalid = o_tvalid_q;
  assign o_tlast  = o_tlast_q;

endmodule
